dmem_wait_responder: RTL and testbench

- Responder (target) side of the processor data-memory bus: answers load/store requests from the MIPS core's memory port (address, write data, write enable) with a req/ready handshake.
- Inserts a programmable number of wait states before responding.
- Sits between the core's data port and a word-addressed RAM array held inside the block.
- Lets the team exercise a stall-capable core against slow memory.

---
 rtl/dmem_wait_responder_if.sv | 22 ++
 rtl/dmem_wait_responder.sv | 110 +++++++++++
 tb/tb_dmem_wait_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_wait_responder_if.sv
// Data-memory bus between a core's load/store port and a wait-state responder.
// The initiator drives req/we/a/wd; the responder returns rd/ready/err/busy.
interface dmem_wait_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, a, wd,
    input  rd, ready, err, busy
  );

  modport slave (
    input  req, we, a, wd,
    output rd, ready, err, busy
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data RAM answering core load/stores after WAIT_CYCLES wait
// states, with misalign/out-of-range rejection and abort on req drop.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_wait_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;

  logic            we_p0;
  logic [31:0]     a_p0;
  logic [31:0]     wd_p0;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic            addr_err;
  logic            resp;

  // Control: state and wait counter, the only reset-controlled storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        // A dropped req abandons the access before anything is committed.
        if (!bus.req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Stage p0: request captured at accept; held until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0 <= bus.we;
      a_p0  <= bus.a;
      wd_p0 <= bus.wd;
    end
  end

  // Upper address bits are range-checked in full so nothing aliases onto idx.
  always_comb begin
    idx      = a_p0[AW+1:2];
    addr_err = (a_p0[1:0] != 2'b00) || (a_p0[31:AW+2] != '0);
    resp     = (state == RESP);
  end

  // Store commits at the close of the response cycle unless reset cuts it off.
  always_ff @(posedge clk) begin
    if (reset && resp && we_p0 && !addr_err) begin
      mem[idx] <= wd_p0;
    end
  end

  assign bus.ready = resp;
  assign bus.err   = resp && addr_err;
  assign bus.busy  = (state != IDLE);
  assign bus.rd    = (resp && !we_p0 && !addr_err) ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) on one clock/reset;
// stimulus queues expected responses, negedge monitors pop and compare.
module tb_dmem_wait_responder;

  logic clk;
  logic reset;

  dmem_wait_responder_if bus0 ();
  dmem_wait_responder_if bus1 ();

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.req = r; bus0.we = w; bus0.a = addr; bus0.wd = data;
    end else begin
      bus1.req = r; bus1.we = w; bus1.a = addr; bus1.wd = data;
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.ready : bus1.ready;
  endfunction

  // Issues one request between edges and holds req until the ready cycle ends.
  task automatic txn(input int sel, input logic w, input logic [31:0] addr,
                     input logic [31:0] data, input logic e_err,
                     input logic [31:0] e_rd, input bit keep);
    exp_t x;
    bit got;
    int wc;
    wc = (sel == 0) ? 2 : 0;
    x.due = cyc + 1 + wc;
    x.err = e_err;
    x.rd  = e_rd;
    if (sel == 0) q0.push_back(x);
    else          q1.push_back(x);
    drive(sel, 1'b1, w, addr, data);
    @(posedge clk);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      check("busy_in_txn", {31'd0, get_busy(sel)}, 32'd1);
      if (get_ready(sel)) got = 1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL txn_timeout: no ready for addr 0x%08h on dut%0d", addr, sel);
    end
    @(posedge clk);
    #1;
    if (!keep) drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      compared++;
      if (bus0.ready) begin
        if (q0.size() == 0) begin
          mismatched++;
          $display("FAIL dut0_unexpected_ready: rd=0x%08h err=%0b at cycle %0d", bus0.rd, bus0.err, cyc);
        end else begin
          x = q0.pop_front();
          if (bus0.rd !== x.rd || bus0.err !== x.err || cyc != x.due) begin
            mismatched++;
            $display("FAIL dut0_resp: rd=0x%08h err=%0b cyc=%0d expected rd=0x%08h err=%0b cyc=%0d",
                     bus0.rd, bus0.err, cyc, x.rd, x.err, x.due);
          end
        end
      end else if (bus0.rd !== 32'd0 || bus0.err !== 1'b0) begin
        mismatched++;
        $display("FAIL dut0_idle_outputs: rd=0x%08h err=%0b expected 0/0", bus0.rd, bus0.err);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      compared++;
      if (bus1.ready) begin
        if (q1.size() == 0) begin
          mismatched++;
          $display("FAIL dut1_unexpected_ready: rd=0x%08h err=%0b at cycle %0d", bus1.rd, bus1.err, cyc);
        end else begin
          x = q1.pop_front();
          if (bus1.rd !== x.rd || bus1.err !== x.err || cyc != x.due) begin
            mismatched++;
            $display("FAIL dut1_resp: rd=0x%08h err=%0b cyc=%0d expected rd=0x%08h err=%0b cyc=%0d",
                     bus1.rd, bus1.err, cyc, x.rd, x.err, x.due);
          end
        end
      end else if (bus1.rd !== 32'd0 || bus1.err !== 1'b0) begin
        mismatched++;
        $display("FAIL dut1_idle_outputs: rd=0x%08h err=%0b expected 0/0", bus1.rd, bus1.err);
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    reset  = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      check("rst_ready0", {31'd0, bus0.ready}, 32'd0);
      check("rst_busy0",  {31'd0, bus0.busy},  32'd0);
      check("rst_busy1",  {31'd0, bus1.busy},  32'd0);
      check("rst_rd0",    bus0.rd,             32'd0);
    end

    // Store then load, two wait states
    txn(0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    txn(0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b1, 32'hFC,  32'h600DF00D, 1'b0, 32'h0,        1'b0);
    txn(0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'h600DF00D, 1'b0);

    // Rejected accesses
    txn(0, 1'b0, 32'h102, 32'h0,        1'b1, 32'h0,        1'b0);
    txn(0, 1'b1, 32'h0,   32'h11111111, 1'b0, 32'h0,        1'b0);
    txn(0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0);
    txn(0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 1'b0);
    txn(0, 1'b1, 32'h2,   32'hFFFFFFFF, 1'b1, 32'h0,        1'b0);
    txn(0, 1'b0, 32'h1000, 32'h0,       1'b1, 32'h0,        1'b0);
    txn(0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111, 1'b0);

    // Abort during wait states
    txn(0, 1'b1, 32'h20,  32'hCAFEF00D, 1'b0, 32'h0,        1'b0);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_wait", {31'd0, bus0.busy}, 32'd1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_drop", {31'd0, bus0.busy}, 32'd0);
    repeat (4) @(negedge clk);
    txn(0, 1'b0, 32'h20,  32'h0,        1'b0, 32'hCAFEF00D, 1'b0);

    // Reset on the edge that would enter the response cycle
    txn(0, 1'b1, 32'h40,  32'h0BADC0DE, 1'b0, 32'h0,        1'b0);
    drive(0, 1'b1, 1'b1, 32'h40, 32'h55555555);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, bus0.busy}, 32'd0);
    repeat (2) @(negedge clk);
    txn(0, 1'b0, 32'h40,  32'h0,        1'b0, 32'h0BADC0DE, 1'b0);
    txn(0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0);

    // Zero-wait responder, back-to-back with req held high
    txn(1, 1'b1, 32'hFC,  32'h12345678, 1'b0, 32'h0,        1'b1);
    @(negedge clk);
    check("zw_gap_busy",  {31'd0, bus1.busy},  32'd0);
    check("zw_gap_ready", {31'd0, bus1.ready}, 32'd0);
    txn(1, 1'b0, 32'hFC,  32'h0,        1'b0, 32'h12345678, 1'b0);
    txn(1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        1'b0);

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
